// File: rtl/sdram_host_arbiter.sv
// sdram_host_arbiter: round-robin two-client arbiter and command sequencer for the SDRAM controller host port
module sdram_host_arbiter #(
  parameter int HADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 16,
  parameter int ISSUE_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   c0_valid,
  input  logic                   c0_we,
  input  logic [HADDR_WIDTH-1:0] c0_addr,
  input  logic [DATA_WIDTH-1:0]  c0_wdata,
  output logic                   c0_ready,
  output logic                   c0_rvalid,
  output logic                   c0_wdone,
  input  logic                   c1_valid,
  input  logic                   c1_we,
  input  logic [HADDR_WIDTH-1:0] c1_addr,
  input  logic [DATA_WIDTH-1:0]  c1_wdata,
  output logic                   c1_ready,
  output logic                   c1_rvalid,
  output logic                   c1_wdone,
  output logic [DATA_WIDTH-1:0]  rdata,
  output logic [HADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   wr_enable,
  output logic [HADDR_WIDTH-1:0] rd_addr,
  output logic                   rd_enable,
  input  logic [DATA_WIDTH-1:0]  rd_data,
  input  logic                   rd_ready,
  input  logic                   busy,
  output logic                   err
);
  localparam int CW = ($clog2(ISSUE_TIMEOUT + 1) > 8) ? $clog2(ISSUE_TIMEOUT + 1) : 8;
  typedef enum logic [1:0] {ARB, ISSUE, WAIT_DONE} state_t;
  state_t state, state_nx;
  logic last, owner, cmd_we, req_we, done_rd, done_wr;
  logic [HADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk)
    state <= rst ? ARB : state_nx;
  always_comb
    state_nx = (state == ARB) ? ((c0_ready | c1_ready) ? ISSUE : ARB) :
               (state == ISSUE) ? (busy ? WAIT_DONE : ISSUE) :
               (busy ? WAIT_DONE : ARB);
  always_comb begin
    c0_ready = (state == ARB) & ~busy & c0_valid & (~c1_valid | last);
    c1_ready = (state == ARB) & ~busy & c1_valid & (~c0_valid | ~last);
    rd_enable = (state == ISSUE) & ~cmd_we;
    wr_enable = (state == ISSUE) & cmd_we;
    req_we = c1_ready ? c1_we : c0_we;
    req_addr = c1_ready ? c1_addr : c0_addr;
    req_wdata = c1_ready ? c1_wdata : c0_wdata;
    done_rd = (state == WAIT_DONE) & rd_ready & ~cmd_we;
    done_wr = (state == WAIT_DONE) & ~busy & cmd_we;
  end
  always_ff @(posedge clk)
    if (rst) begin
      last <= 1'b1;
      owner <= 1'b0;
      cmd_we <= 1'b0;
      rd_addr <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      rdata <= '0;
      c0_rvalid <= 1'b0;
      c1_rvalid <= 1'b0;
      c0_wdone <= 1'b0;
      c1_wdone <= 1'b0;
      cnt <= '0;
      err <= 1'b0;
    end else begin
      c0_rvalid <= done_rd & ~owner;
      c1_rvalid <= done_rd & owner;
      c0_wdone <= done_wr & ~owner;
      c1_wdone <= done_wr & owner;
      if (done_rd) rdata <= rd_data;
      cnt <= (state == ISSUE) ? cnt + CW'(cnt != '1) : '0;
      if ((state == ISSUE) && (cnt == CW'(ISSUE_TIMEOUT))) err <= 1'b1;
      if (c0_ready | c1_ready) begin
        owner <= c1_ready;
        last <= c1_ready;
        cmd_we <= req_we;
        if (req_we) begin
          wr_addr <= req_addr;
          wr_data <= req_wdata;
        end else rd_addr <= req_addr;
      end
    end
endmodule

// File: tb/tb_sdram_host_arbiter.sv
// tb_sdram_host_arbiter: directed checks of arbitration, sequencing, timeout and reset against a controller model
module tb_sdram_host_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic c0_valid = 1'b0, c1_valid = 1'b0, c0_we = 1'b0, c1_we = 1'b0;
  logic [23:0] c0_addr = '0, c1_addr = '0;
  logic [15:0] c0_wdata = '0, c1_wdata = '0;
  logic c0_ready, c1_ready, c0_rvalid, c1_rvalid, c0_wdone, c1_wdone;
  logic wr_enable, rd_enable, err, rd_ready, busy;
  logic [15:0] rdata, wr_data, rd_data;
  logic [23:0] wr_addr, rd_addr;
  always #5 clk = ~clk;
  sdram_host_arbiter dut (
    .clk(clk), .rst(rst),
    .c0_valid(c0_valid), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
    .c0_ready(c0_ready), .c0_rvalid(c0_rvalid), .c0_wdone(c0_wdone),
    .c1_valid(c1_valid), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
    .c1_ready(c1_ready), .c1_rvalid(c1_rvalid), .c1_wdone(c1_wdone),
    .rdata(rdata), .wr_addr(wr_addr), .wr_data(wr_data), .wr_enable(wr_enable),
    .rd_addr(rd_addr), .rd_enable(rd_enable), .rd_data(rd_data), .rd_ready(rd_ready),
    .busy(busy), .err(err)
  );
  int cyc = 0, blocked_until = 0, accepts = 0, phase = 0;
  logic m_we = 1'b0;
  logic [23:0] m_addr = '0;
  logic [15:0] m_data = '0;
  logic [15:0] mem [256];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (phase == 0) begin
      if ((rd_enable || wr_enable) && cyc >= blocked_until) begin
        phase <= 1;
        m_we <= wr_enable;
        m_addr <= wr_enable ? wr_addr : rd_addr;
        m_data <= wr_data;
        accepts <= accepts + 1;
      end
    end else phase <= (phase == 5) ? 0 : phase + 1;
    if (phase == 2 && m_we) mem[m_addr[7:0]] <= m_data;
  end
  always_comb begin
    busy = (phase >= 2);
    rd_ready = (phase == 5) && !m_we;
    rd_data = (m_addr == 24'h012345) ? 16'hBEEF : mem[m_addr[7:0]];
  end
  int en_cyc = 0, both_en = 0, glitch = 0, r0 = 0, r1 = 0, w0 = 0, w1 = 0;
  int wdone_cyc = -1, rden_cyc = -1;
  logic [15:0] last_rdata = '0, prev_wr_data = '0;
  logic prev_rd = 1'b0, prev_wr = 1'b0;
  logic [23:0] prev_rd_addr = '0, prev_wr_addr = '0;
  int gq[$];
  logic [16:0] wq[$];
  always @(negedge clk) begin
    if (rd_enable || wr_enable) en_cyc <= en_cyc + 1;
    if (rd_enable && wr_enable) both_en <= both_en + 1;
    if ((rd_enable && prev_rd && rd_addr != prev_rd_addr) ||
        (wr_enable && prev_wr && (wr_addr != prev_wr_addr || wr_data != prev_wr_data)))
      glitch <= glitch + 1;
    if (rd_enable && !prev_rd) rden_cyc <= cyc;
    prev_rd <= rd_enable;
    prev_wr <= wr_enable;
    prev_rd_addr <= rd_addr;
    prev_wr_addr <= wr_addr;
    prev_wr_data <= wr_data;
    if (c0_rvalid) begin
      r0 <= r0 + 1;
      last_rdata <= rdata;
    end
    if (c1_rvalid) r1 <= r1 + 1;
    if (c0_wdone) begin
      w0 <= w0 + 1;
      wdone_cyc <= cyc;
    end
    if (c1_wdone) w1 <= w1 + 1;
    if (c0_wdone || c1_wdone) wq.push_back({c1_wdone, wr_data});
    if (c0_valid && c0_ready) gq.push_back(0);
    if (c1_valid && c1_ready) gq.push_back(1);
  end
  int n_chk = 0, n_pass = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic send(input logic c, input logic we, input logic [23:0] a, input logic [15:0] d,
                      input int hold, output int waited);
    int k;
    k = 0;
    @(posedge clk);
    #1;
    blocked_until = cyc + 1 + hold;
    if (c) begin
      c1_valid = 1'b1; c1_we = we; c1_addr = a; c1_wdata = d;
    end else begin
      c0_valid = 1'b1; c0_we = we; c0_addr = a; c0_wdata = d;
    end
    do begin
      @(negedge clk);
      k++;
    end while (!(c ? c1_ready : c0_ready) && k < 400);
    check("send_ready", 32'(k < 400), 1);
    waited = k;
    @(posedge clk);
    #1;
    c0_valid = 1'b0;
    c1_valid = 1'b0;
  endtask
  task automatic wait_done(input int target);
    int k;
    k = 0;
    while (r0 + r1 + w0 + w1 < target && k < 300) begin
      @(posedge clk);
      k++;
    end
    check("done_wait", 32'(k < 300), 1);
    repeat (2) @(posedge clk);
    #1;
  endtask
  initial begin
    int k, waited, tgt, b_en, b_acc, b_r0, b_r1, b_w0, b_g;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_ctl", {rd_enable, wr_enable, c0_ready, c1_ready}, 0);
    check("reset_strobes", {c0_rvalid, c1_rvalid, c0_wdone, c1_wdone, err}, 0);
    check("reset_rd_addr", rd_addr, 0);
    check("reset_wr_addr", wr_addr, 0);
    check("reset_wr_data", wr_data, 0);
    check("reset_rdata", rdata, 0);
    @(posedge clk);
    #1;
    c0_valid = 1'b1; c0_we = 1'b1; c0_addr = 24'h10; c0_wdata = 16'h1111;
    c1_valid = 1'b1; c1_we = 1'b1; c1_addr = 24'h20; c1_wdata = 16'h2222;
    blocked_until = 0;
    k = 0;
    while (gq.size() < 4 && k < 400) begin
      @(posedge clk);
      k++;
    end
    #1;
    c0_valid = 1'b0;
    c1_valid = 1'b0;
    check("rr_grant_count", gq.size(), 4);
    wait_done(4);
    for (int i = 0; i < 4; i++) check("rr_grant_owner", gq[i], i % 2);
    check("rr_wdone_count", wq.size(), 4);
    for (int i = 0; i < 4; i++) check("rr_wdone_owner_data", wq[i], (i % 2) ? 32'h12222 : 32'h01111);
    check("rr_w0", w0, 2);
    check("rr_w1", w1, 2);
    b_en = en_cyc; b_r0 = r0; b_r1 = r1;
    tgt = r0 + r1 + w0 + w1 + 1;
    send(1'b0, 1'b0, 24'h012345, 16'h0, 0, waited);
    check("rd_ready_same_cycle", waited, 1);
    wait_done(tgt);
    check("rd_enable_cycles", en_cyc - b_en, 3);
    check("rd_addr", rd_addr, 24'h012345);
    check("rd_c0_rvalid_cycles", r0 - b_r0, 1);
    check("rd_c1_rvalid_cycles", r1 - b_r1, 0);
    check("rd_rdata", last_rdata, 16'hBEEF);
    b_en = en_cyc; b_acc = accepts; b_w0 = w0;
    tgt = r0 + r1 + w0 + w1 + 1;
    send(1'b0, 1'b1, 24'h33, 16'h3333, 12, waited);
    wait_done(tgt);
    check("refresh_enable_cycles", en_cyc - b_en, 15);
    check("refresh_accepts", accepts - b_acc, 1);
    check("refresh_wdone", w0 - b_w0, 1);
    check("refresh_err", err, 0);
    check("refresh_wr_addr", wr_addr, 24'h33);
    check("addr_stable", glitch, 0);
    send(1'b1, 1'b0, 24'h55, 16'h0, 1 << 30, waited);
    repeat (250) @(posedge clk);
    #1;
    check("timeout_err_early", err, 0);
    check("timeout_rd_enable_held", rd_enable, 1);
    repeat (10) @(posedge clk);
    #1;
    check("timeout_err_set", err, 1);
    repeat (20) @(posedge clk);
    #1;
    check("timeout_err_sticky", err, 1);
    check("timeout_rd_addr", rd_addr, 24'h55);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    blocked_until = 0;
    check("timeout_err_cleared", err, 0);
    check("timeout_enable_cleared", rd_enable, 0);
    b_r1 = r1;
    send(1'b1, 1'b0, 24'h44, 16'h0, 0, waited);
    repeat (3) @(posedge clk);
    #1;
    check("midrst_in_wait_done", {busy, rd_enable}, 2'b10);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_enables", {rd_enable, wr_enable}, 0);
    check("midrst_rdata", rdata, 0);
    check("midrst_rd_addr", rd_addr, 0);
    check("midrst_wr_addr", wr_addr, 0);
    check("midrst_wr_data", wr_data, 0);
    repeat (10) @(posedge clk);
    #1;
    check("midrst_no_c1_rvalid", r1 - b_r1, 0);
    b_g = gq.size();
    tgt = r0 + r1 + w0 + w1 + 1;
    c0_valid = 1'b1; c0_we = 1'b1; c0_addr = 24'h60; c0_wdata = 16'h6666;
    c1_valid = 1'b1; c1_we = 1'b1; c1_addr = 24'h61; c1_wdata = 16'h7777;
    blocked_until = 0;
    k = 0;
    while (gq.size() <= b_g && k < 400) begin
      @(posedge clk);
      k++;
    end
    #1;
    c0_valid = 1'b0;
    c1_valid = 1'b0;
    check("midrst_first_grant", gq[b_g], 0);
    wait_done(tgt);
    tgt = r0 + r1 + w0 + w1 + 2;
    send(1'b0, 1'b1, 24'h200, 16'hA5A5, 0, waited);
    send(1'b0, 1'b0, 24'h200, 16'h0, 0, waited);
    wait_done(tgt);
    check("wr_rd_order", 32'(wdone_cyc < rden_cyc), 1);
    check("wr_rd_data", last_rdata, 16'hA5A5);
    check("never_both_enables", both_en, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/sdram_host_arbiter.md
# sdram_host_arbiter

Two-client request arbiter and command sequencer sitting directly upstream of the SDRAM controller's single-word host interface. It accepts read/write requests from two independent clients with valid/ready handshakes and picks between them round-robin. It drives the controller's `wr_*`/`rd_*` enables under the controller's `busy` protocol, and routes each read word or write completion back to the client that issued it. Enables are held until the controller visibly accepts them, so commands presented during controller init or refresh are never lost.

## Interface
- `HADDR_WIDTH`, default 24: host word address width (bank+row+col).
- `DATA_WIDTH`, default 16: data word width.
- `ISSUE_TIMEOUT`, default 255: cycles in ISSUE before `err` is flagged.
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset (one clock; polarity and synchronicity fixed).
- `c0_valid`, `c1_valid` in 1: client N request present.
- `c0_we`, `c1_we` in 1: 1 = write, 0 = read.
- `c0_addr`, `c1_addr` in HADDR_WIDTH: request word address.
- `c0_wdata`, `c1_wdata` in DATA_WIDTH: write data.
- `c0_ready`, `c1_ready` out 1: request accepted when valid&ready at posedge.
- `c0_rvalid`, `c1_rvalid` out 1: one-cycle read-data strobe.
- `c0_wdone`, `c1_wdone` out 1: one-cycle write-complete strobe.
- `rdata` out DATA_WIDTH: read data, shared; qualified by `cN_rvalid`.
- `wr_addr`, `rd_addr` out HADDR_WIDTH; `wr_data` out DATA_WIDTH; `wr_enable`, `rd_enable` out 1: to controller.
- `rd_data` in DATA_WIDTH; `rd_ready` in 1; `busy` in 1: from controller.
- `err` out 1: sticky, ISSUE exceeded ISSUE_TIMEOUT cycles.

## Operation
- FSM states: ARB, ISSUE, WAIT_DONE.
- ARB:
  - `cN_ready` is combinational: high only for the round-robin winner among valid clients, and only when `busy==0`.
  - On transfer, latch we/addr/wdata and the owner ID into a command register, then go to ISSUE.
- Round-robin: `last` pointer resets to 1, so client 0 wins the first contention. When both clients are valid, grant the client that is not `last`. When one is valid, grant it. `last` updates on every grant.
- ISSUE:
  - Drive `rd_enable` (read) or `wr_enable` (write) high, with `rd_addr`/`wr_addr`/`wr_data` from the command register, held stable every cycle.
  - On the first cycle `busy==1` is sampled, deassert both enables next cycle and go to WAIT_DONE.
  - While ISSUE is held, the controller may be in init or refresh; in those states it ignores enables. This is normal operation, not an error.
- WAIT_DONE:
  - Read: on `rd_ready==1`, register `rd_data` into `rdata` and pulse the owner's `cN_rvalid` the next cycle.
  - On `busy==0`: if write, pulse the owner's `cN_wdone` the next cycle. Both read and write then return to ARB.
- Address/data outputs not in use hold their last value. Both enables are never high together.
- Timeout counter: 8+ bits, cleared on entry to ISSUE, saturating. If it reaches ISSUE_TIMEOUT while still in ISSUE, set `err` (sticky until `rst`). The command keeps being held; nothing aborts.
- Reset values: FSM=ARB, `last`=1, all enables/ready/rvalid/wdone=0, `rdata`/addr/data outputs=0, `err`=0, counter=0.
- Reset mid-operation drops any in-flight command with no completion strobe. Clients must reissue.

## Timing
- Request accepted at edge t → enable high from cycle t+1.
- Controller accepts the enable at edge end-of-(t+1) when it is in idle, so `busy` is first seen high in t+3. Enables are low from t+4.
- Extra cycles on enable (t+2, t+3) carry identical addr/data; this re-latch is harmless by design.
- `rd_ready` from the controller arrives one cycle before `busy` falls. `cN_rvalid` is one cycle after `rd_ready`.
- `cN_wdone` is one cycle after `busy` is first sampled low. ARB is re-entered in the same cycle, so the next `cN_ready` can assert that cycle.
- One command outstanding at a time. Throughput is bounded by controller busy time plus 2 arbitration cycles.

## Test plan
- Single read, c0, addr 0x012345, controller model returns 0xBEEF:
  - `rd_enable` held until `busy` is seen, with `rd_addr`=0x012345.
  - `c0_rvalid`=1 for exactly one cycle with `rdata`=0xBEEF; `c1_rvalid` stays 0.
- Both clients valid continuously, c0 write 0x1111, c1 write 0x2222:
  - Grants alternate c0,c1,c0,c1.
  - `wr_data` matches the owner each time; `cN_wdone` goes to the correct owner.
- Request during model refresh, `busy`=0 but accept delayed 12 cycles:
  - Enable held the full 12 cycles with stable address.
  - Exactly one command executes; `err` stays 0.
- Model never accepts: `err` rises after 255 ISSUE cycles and stays high until `rst`.
- `rst` pulsed while in WAIT_DONE for a c1 read:
  - No `c1_rvalid`; all outputs at reset values next cycle.
  - The first subsequent contention grants c0.
- Write then read to the same address 0x000200, data 0xA5A5:
  - `c0_wdone` is seen before the read's `rd_enable`.
  - The read returns 0xA5A5.
